// File: rtl/ram_burst_arbiter.sv
// Two-requester RAM burst arbiter: one writer, one reader, round-robin.
// A granted requester gets BURST_LEN consecutive beats with an incrementing,
// wrapping address, followed by a one-cycle DONE with a done pulse.
// Every output comes straight from a register.
//
// state | meaning
// IDLE  | no owner; requests are arbitrated on the next edge
// BURST | one beat per cycle to the granted requester
// DONE  | burst finished; done pulse, grant released, pointer updated
module ram_burst_arbiter #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int BURST_LEN     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] wr_base,
  input  logic                     rd_req,
  input  logic [ADDRESS_WIDTH-1:0] rd_base,
  output logic                     wr_gnt,
  output logic                     rd_gnt,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic                     wr_done,
  output logic                     rd_done,
  output logic                     busy
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [CW-1:0]            r_beat, w_beat_nxt;
  logic                     r_wr_gnt, w_wr_gnt_nxt;
  logic                     r_rd_gnt, w_rd_gnt_nxt;
  logic                     r_en, w_en_nxt;
  logic                     r_we;
  logic                     r_wr_done, w_wr_done_nxt;
  logic                     r_rd_done, w_rd_done_nxt;
  logic                     r_busy;
  // 1 = reader has priority when both request (writer was served last)
  logic                     r_rr_rd, w_rr_rd_nxt;
  logic                     w_pick_rd;
  logic                     w_own_req;

  assign w_pick_rd = rd_req & (~wr_req | r_rr_rd);
  assign w_own_req = r_rd_gnt ? rd_req : wr_req;

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_beat    <= '0;
      r_wr_gnt  <= 1'b0;
      r_rd_gnt  <= 1'b0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_busy    <= 1'b0;
      r_rr_rd   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_beat    <= w_beat_nxt;
      r_wr_gnt  <= w_wr_gnt_nxt;
      r_rd_gnt  <= w_rd_gnt_nxt;
      r_en      <= w_en_nxt;
      r_we      <= w_en_nxt & w_wr_gnt_nxt;
      r_wr_done <= w_wr_done_nxt;
      r_rd_done <= w_rd_done_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_rr_rd   <= w_rr_rd_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_beat_nxt    = r_beat;
    w_wr_gnt_nxt  = r_wr_gnt;
    w_rd_gnt_nxt  = r_rd_gnt;
    w_en_nxt      = 1'b0;
    w_wr_done_nxt = 1'b0;
    w_rd_done_nxt = 1'b0;
    w_rr_rd_nxt   = r_rr_rd;
    case (r_state)
      IDLE: begin
        if (wr_req || rd_req) begin
          w_state_nxt  = BURST;
          w_addr_nxt   = w_pick_rd ? rd_base : wr_base;
          w_beat_nxt   = '0;
          w_wr_gnt_nxt = ~w_pick_rd;
          w_rd_gnt_nxt = w_pick_rd;
          w_en_nxt     = 1'b1;
        end
      end
      BURST: begin
        if (!w_own_req) begin
          // Abort: owner withdrew; no done pulse, pointer left alone
          w_state_nxt  = IDLE;
          w_beat_nxt   = '0;
          w_wr_gnt_nxt = 1'b0;
          w_rd_gnt_nxt = 1'b0;
        end else if (r_beat == LAST_BEAT) begin
          w_state_nxt   = DONE;
          w_beat_nxt    = '0;
          w_wr_gnt_nxt  = 1'b0;
          w_rd_gnt_nxt  = 1'b0;
          w_wr_done_nxt = r_wr_gnt;
          w_rd_done_nxt = r_rd_gnt;
          w_rr_rd_nxt   = r_wr_gnt;
        end else begin
          w_beat_nxt = r_beat + CW'(1);
          w_addr_nxt = r_addr + ADDRESS_WIDTH'(1);
          w_en_nxt   = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_wr_gnt_nxt = 1'b0;
        w_rd_gnt_nxt = 1'b0;
      end
    endcase
  end

  assign wr_gnt   = r_wr_gnt;
  assign rd_gnt   = r_rd_gnt;
  assign ram_addr = r_addr;
  assign ram_en   = r_en;
  assign ram_we   = r_we;
  assign wr_done  = r_wr_done;
  assign rd_done  = r_rd_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ram_burst_arbiter.sv
// Directed bench for ram_burst_arbiter: outputs sampled on the falling edge,
// inputs changed on the falling edge.
module tb_ram_burst_arbiter;

  localparam int AW = 14;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_base, rd_base;
  logic          wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy;
  logic [AW-1:0] ram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  ram_burst_arbiter #(.ADDRESS_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_base(wr_base),
    .rd_req(rd_req), .rd_base(rd_base),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
    .ram_addr(ram_addr), .ram_en(ram_en), .ram_we(ram_we),
    .wr_done(wr_done), .rd_done(rd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Grants must never overlap and a read grant never carries a write strobe
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if (((wr_gnt && rd_gnt) !== 1'b0) || ((ram_we && rd_gnt) !== 1'b0)) begin
        n_fail++;
        $display("FAIL exclusivity t=%0t: wr_gnt=%b rd_gnt=%b ram_we=%b, required no overlap",
                 $time, wr_gnt, rd_gnt, ram_we);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic hold_reset();
    reset   = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_base = '0;
    rd_base = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    hold_reset();
    n_checks++;
    if ({wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy});
    end
    n_checks++;
    if (ram_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d required 0", ram_addr);
    end
  endtask

  task automatic test_single_write();
    hold_reset();
    wr_base = AW'(100);
    wr_req  = 1'b1;
    reset   = 1'b1;
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      n_checks++;
      if (ram_addr !== AW'(100 + i)) begin
        n_fail++;
        $display("FAIL single_addr beat %0d: got %0d required %0d", i, ram_addr, 100 + i);
      end
      n_checks++;
      if ({wr_gnt, rd_gnt, ram_en, ram_we} !== 4'b1011) begin
        n_fail++;
        $display("FAIL single_ctrl beat %0d: got %b required 1011", i,
                 {wr_gnt, rd_gnt, ram_en, ram_we});
      end
      if (i == 2) wr_base = AW'(999);
    end
    @(negedge clk);
    n_checks++;
    if ({wr_gnt, ram_en, ram_we, wr_done, rd_done, busy} !== 6'b000101) begin
      n_fail++;
      $display("FAIL single_done: got %b required 000101",
               {wr_gnt, ram_en, ram_we, wr_done, rd_done, busy});
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wr_done, ram_en, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_idle: got %b required 000", {wr_done, ram_en, busy});
    end
  endtask

  task automatic test_contention();
    hold_reset();
    wr_base = AW'(0);
    rd_base = AW'(500);
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    reset   = 1'b1;
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_gnt, rd_gnt, ram_en, ram_we} !== 4'b1011 || ram_addr !== AW'(i)) begin
        n_fail++;
        $display("FAIL contention_wr beat %0d: ctrl %b addr %0d required 1011 addr %0d",
                 i, {wr_gnt, rd_gnt, ram_en, ram_we}, ram_addr, i);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({wr_done, ram_en, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL contention_wr_done: got %b required 101", {wr_done, ram_en, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({wr_gnt, rd_gnt, ram_en, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL contention_gap: got %b required 0000", {wr_gnt, rd_gnt, ram_en, busy});
    end
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_gnt, rd_gnt, ram_en, ram_we} !== 4'b0110 || ram_addr !== AW'(500 + i)) begin
        n_fail++;
        $display("FAIL contention_rd beat %0d: ctrl %b addr %0d required 0110 addr %0d",
                 i, {wr_gnt, rd_gnt, ram_en, ram_we}, ram_addr, 500 + i);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({rd_done, wr_done, ram_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL contention_rd_done: got %b required 100", {rd_done, wr_done, ram_en});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({wr_gnt, rd_gnt} !== 2'b10 || ram_addr !== AW'(0)) begin
      n_fail++;
      $display("FAIL contention_rr: gnt %b addr %0d required 10 addr 0",
               {wr_gnt, rd_gnt}, ram_addr);
    end
  endtask

  task automatic test_wrap();
    int pulses = 0;
    hold_reset();
    rd_base = AW'(16380);
    rd_req  = 1'b1;
    reset   = 1'b1;
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      pulses += int'(rd_done);
      n_checks++;
      if (ram_addr !== AW'((16380 + i) % 16384) || rd_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap_addr beat %0d: got %0d gnt %b required %0d gnt 1",
                 i, ram_addr, rd_gnt, (16380 + i) % 16384);
      end
    end
    @(negedge clk);
    pulses += int'(rd_done);
    rd_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      pulses += int'(rd_done);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL wrap_done_pulses: got %0d required 1", pulses);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_abort();
    hold_reset();
    wr_base = AW'(40);
    rd_base = AW'(700);
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    reset   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (ram_addr !== AW'(40 + i) || wr_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_beat %0d: addr %0d gnt %b required %0d gnt 1",
                 i, ram_addr, wr_gnt, 40 + i);
      end
    end
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b required 0000000",
               {wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy});
    end
    wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_gnt, rd_gnt} !== 2'b10 || ram_addr !== AW'(40)) begin
      n_fail++;
      $display("FAIL abort_priority: gnt %b addr %0d required 10 addr 40",
               {wr_gnt, rd_gnt}, ram_addr);
    end
  endtask

  task automatic test_reset_mid_burst();
    hold_reset();
    wr_base = AW'(200);
    wr_req  = 1'b1;
    reset   = 1'b1;
    repeat (BL + 1) @(negedge clk);
    n_checks++;
    if (wr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_first_done: got %b required 1", wr_done);
    end
    rd_base = AW'(300);
    rd_req  = 1'b1;
    @(negedge clk);
    repeat (6) @(negedge clk);
    n_checks++;
    if (ram_addr !== AW'(305) || rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_beat5: addr %0d gnt %b required 305 gnt 1", ram_addr, rd_gnt);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %b required 0000000",
               {wr_gnt, rd_gnt, ram_en, ram_we, wr_done, rd_done, busy});
    end
    n_checks++;
    if (ram_addr !== '0) begin
      n_fail++;
      $display("FAIL midrst_addr: got %0d required 0", ram_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wr_gnt, rd_gnt} !== 2'b10 || ram_addr !== AW'(200)) begin
      n_fail++;
      $display("FAIL midrst_writer_first: gnt %b addr %0d required 10 addr 200",
               {wr_gnt, rd_gnt}, ram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_wrap();
    test_abort();
    test_reset_mid_burst();
    hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
